c_splitter_n: RTL and testbench
===============================

Name: c_splitter_n

Overview:
- Clocked, parametrised successor to the 4-way drive/free splitter (fork). It accepts one token per upstream drive pulse and latches its data.
- Each token is either copied whole or cut into per-channel slices, then fanned out to NUM_CH downstream channels. Only channels enabled by a per-token mask receive it.
- Free pulses from the enabled channels are collected. When all have returned, the block waits a programmable delay and then returns a single free pulse upstream.
- Adds what the fixed fork lacks: channel count, channel masking, data buffering, token counting and protocol-error flagging.

Parameters:
- NUM_CH, 4, number of downstream channels (2..16).
- DATA_WIDTHI, 32, input data width.
- COPY, 0, 1 = every channel gets all of i_data; 0 = split mode.
- SLICE_WIDTH, 8, per-channel width in split mode. Requires NUM_CH*SLICE_WIDTH <= DATA_WIDTHI.
- FREE_DELAY, 4, extra cycles between the last downstream free and o_free (0..255).
- CNT_WIDTH, 16, width of the accepted-token counter.

Ports:
- clk, in, 1, clock.
- rstn, in, 1, asynchronous active-low reset.
- i_drive, in, 1, upstream token-valid pulse; each high cycle is one request.
- i_data, in, DATA_WIDTHI, token data; sampled on the accepting edge.
- i_mask, in, NUM_CH, channel enable for this token; sampled with i_data.
- i_freeNext_n, in, NUM_CH, per-channel free pulses from downstream.
- o_free, out, 1, one-cycle free pulse to upstream.
- o_driveNext_n, out, NUM_CH, per-channel one-cycle drive pulses.
- o_data_n, out, NUM_CH*OW, packed channel data, channel k at [k*OW +: OW], where OW = COPY ? DATA_WIDTHI : SLICE_WIDTH.
- o_busy, out, 1, high whenever the FSM is not IDLE.
- o_err, out, 1, sticky protocol-error flag.
- o_token_cnt, out, CNT_WIDTH, count of accepted tokens.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; all outputs 0, including o_data_n, pending vector, delay counter, o_err and o_token_cnt. Reset mid-operation aborts the token; no o_free is emitted for it.
- FSM states: IDLE, ISSUE, WAIT_FREE, DELAY, FREE.
- IDLE + i_drive:
  - latch i_data into the data register; pending <= i_mask; o_token_cnt += 1 (wraps at 2^CNT_WIDTH).
  - if i_mask != 0, next state ISSUE; if i_mask == 0, skip to DELAY (or to FREE if FREE_DELAY == 0).
- ISSUE (one cycle): o_driveNext_n = pending; next state WAIT_FREE.
- Free collection (ISSUE or WAIT_FREE): i_freeNext_n[k] with pending[k]=1 clears pending[k]. Several frees in the same cycle are all accepted.
- Leaving WAIT_FREE: once pending becomes 0, go to DELAY and load the counter with FREE_DELAY; if FREE_DELAY == 0, go straight to FREE.
- DELAY: counter decrements by 1 per cycle; at 1 the next state is FREE.
- FREE (one cycle): o_free = 1; next state IDLE. A new i_drive in this same cycle is not accepted.
- Latency:
  - drive accepted at edge t → o_driveNext_n high in cycle t+1.
  - last free sampled at edge t → o_free high in cycle t+1+FREE_DELAY.
  - a masked-all-zero token gives o_free at cycle t+1+FREE_DELAY after acceptance.
- Data: o_data_n is driven from the data register, stable from ISSUE until the next acceptance.
  - Split mode: channel 0 takes the most significant slice, i_data[DATA_WIDTHI-1 -: SLICE_WIDTH]; channel k takes i_data[DATA_WIDTHI-1-k*SLICE_WIDTH -: SLICE_WIDTH]. Unused low bits are discarded.
  - Masked-off channels still see their data, but receive no drive.
- Errors: o_err sets and stays set until reset, on either of:
  - i_drive while state != IDLE; the request is ignored and not counted;
  - i_freeNext_n[k] with pending[k]=0, in any state; the pulse is otherwise ignored.

Decomposition:
- Package c_splitter_pkg: FSM state enum (3-bit encoding), OW width function, parameter-legality checks (NUM_CH range, slice fit).
- Sub-module free_delay_timer (8-bit loadable down-counter with a done flag), instantiated once.

Test Plan:
- Defaults, i_data=32'hA1B2C3D4, mask 4'hF, frees on ch0..3 at cycles 3,5,5,8 → o_data_n slices ch0=A1, ch1=B2, ch2=C3, ch3=D4; one o_driveNext_n=4'hF pulse at cycle 1; o_free only at cycle 13; o_token_cnt=1.
- COPY=1, mask 4'b0101 → drive pulses only on ch0 and ch2, each carrying the full 32-bit word; frees from ch0 and ch2 alone complete the token.
- Mask 0, FREE_DELAY=0 → o_free at cycle 1 after acceptance; no drive pulses; o_err=0.
- Second i_drive during WAIT_FREE; spurious free on a masked channel → o_err=1; o_token_cnt unchanged by the ignored drive; the original token still completes normally.
- rstn low while in DELAY → all outputs 0 immediately; no o_free; after release a new token is accepted with o_token_cnt=1.
- CNT_WIDTH=2, five tokens → o_token_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/c_splitter_pkg.sv
// ---------------------------------------------------------------------------
// c_splitter_pkg
// Shared types and helpers for the c_splitter_n token fork.
//   - state_e      : FSM state encoding (3 bits)
//   - DELAY_W      : width of the free-delay down-counter
//   - calcOw()     : per-channel output width (full word or one slice)
//   - paramsLegal(): elaboration-time parameter sanity check
// ---------------------------------------------------------------------------
package c_splitter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_FREE = 3'd2,
    ST_DELAY     = 3'd3,
    ST_FREE      = 3'd4
  } state_e;

  localparam int DELAY_W = 8;
  localparam int MIN_CH  = 2;
  localparam int MAX_CH  = 16;

  // Copy mode hands every channel the whole word, split mode one slice.
  function automatic int calcOw(input int copy, input int dataWidth, input int sliceWidth);
    return (copy != 0) ? dataWidth : sliceWidth;
  endfunction

  // Channel count must be in range, the delay must fit the 8-bit timer and,
  // in split mode, all slices must fit inside the input word.
  function automatic bit paramsLegal(input int numCh, input int dataWidth, input int copy,
                                     input int sliceWidth, input int freeDelay);
    return (numCh >= MIN_CH) && (numCh <= MAX_CH) &&
           (freeDelay >= 0) && (freeDelay < (1 << DELAY_W)) &&
           ((copy != 0) || ((sliceWidth > 0) && (numCh * sliceWidth <= dataWidth)));
  endfunction

endpackage

// File: rtl/c_splitter_n_free_delay_timer.sv
// ---------------------------------------------------------------------------
// free_delay_timer
// 8-bit loadable down-counter used to space the upstream free pulse.
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   load_i      : load load_val_i into the counter this cycle
//   load_val_i  : value to load
//   done_o      : high while the counter holds 1 (last delay cycle)
// ---------------------------------------------------------------------------
module free_delay_timer
  import c_splitter_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               load_i,
  input  logic [DELAY_W-1:0] load_val_i,
  output logic               done_o
);

  logic [DELAY_W-1:0] cnt_q;
  logic [DELAY_W-1:0] cnt_d;

  // Next count: a load wins, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DELAY_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Seeing 1 means this is the final delay cycle, so the FSM moves on next edge.
  assign done_o = (cnt_q == DELAY_W'(1));

endmodule

// File: rtl/c_splitter_n.sv
// ---------------------------------------------------------------------------
// c_splitter_n
// Parametrised drive/free fork. Accepts one token per upstream drive,
// latches its data, fans it out (whole or sliced) to the channels enabled
// by the token mask, collects their frees, waits FREE_DELAY cycles and
// returns a single free upstream.
// Ports:
//   clk, rstn       : clock, asynchronous active-low reset
//   i_drive         : upstream token-valid pulse
//   i_data          : token data, sampled on the accepting edge
//   i_mask          : per-token channel enable, sampled with i_data
//   i_freeNext_n    : per-channel free pulses from downstream
//   o_free          : one-cycle free pulse to upstream
//   o_driveNext_n   : per-channel one-cycle drive pulses
//   o_data_n        : packed channel data, channel k at [k*OW +: OW]
//   o_busy          : FSM not idle
//   o_err           : sticky protocol-error flag
//   o_token_cnt     : accepted-token counter (wrapping)
// ---------------------------------------------------------------------------
module c_splitter_n
  import c_splitter_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_WIDTHI = 32,
  parameter int COPY        = 0,
  parameter int SLICE_WIDTH = 8,
  parameter int FREE_DELAY  = 4,
  parameter int CNT_WIDTH   = 16,
  localparam int OW         = calcOw(COPY, DATA_WIDTHI, SLICE_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_drive,
  input  logic [DATA_WIDTHI-1:0] i_data,
  input  logic [NUM_CH-1:0]      i_mask,
  input  logic [NUM_CH-1:0]      i_freeNext_n,
  output logic                   o_free,
  output logic [NUM_CH-1:0]      o_driveNext_n,
  output logic [NUM_CH*OW-1:0]   o_data_n,
  output logic                   o_busy,
  output logic                   o_err,
  output logic [CNT_WIDTH-1:0]   o_token_cnt
);

  if (!paramsLegal(NUM_CH, DATA_WIDTHI, COPY, SLICE_WIDTH, FREE_DELAY)) begin : gen_bad_params
    $error("c_splitter_n: illegal parameter combination");
  end

  localparam logic [DELAY_W-1:0] FREE_DELAY_V = DELAY_W'(FREE_DELAY);

  state_e                 state_q, state_d;
  logic [NUM_CH-1:0]      pending_q, pending_d;
  logic [DATA_WIDTHI-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   timerLoad;
  logic                   timerDone;

  free_delay_timer u_timer (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (timerLoad),
    .load_val_i (FREE_DELAY_V),
    .done_o     (timerDone)
  );

  // Next-state logic. Frees are collected in ISSUE and WAIT_FREE; the exit
  // decision looks at the already-cleared pending vector so the last free
  // moves straight into the delay phase without an extra idle cycle.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    timerLoad = 1'b0;

    if ((state_q == ST_ISSUE) || (state_q == ST_WAIT_FREE)) begin
      pending_d = pending_q & ~i_freeNext_n;
    end

    // A free on a channel that owes nothing, or a drive while busy, is a
    // protocol error; both are otherwise ignored.
    if ((i_freeNext_n & ~pending_q) != '0) begin
      err_d = 1'b1;
    end
    if (i_drive && (state_q != ST_IDLE)) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (i_drive) begin
          data_d    = i_data;
          pending_d = i_mask;
          cnt_d     = cnt_q + CNT_WIDTH'(1);
          if (i_mask != '0) begin
            state_d = ST_ISSUE;
          end else if (FREE_DELAY == 0) begin
            state_d = ST_FREE;
          end else begin
            state_d   = ST_DELAY;
            timerLoad = 1'b1;
          end
        end
      end
      ST_ISSUE, ST_WAIT_FREE: begin
        if (pending_d == '0) begin
          if (FREE_DELAY == 0) begin
            state_d = ST_FREE;
          end else begin
            state_d   = ST_DELAY;
            timerLoad = 1'b1;
          end
        end else begin
          state_d = ST_WAIT_FREE;
        end
      end
      ST_DELAY: begin
        if (timerDone) begin
          state_d = ST_FREE;
        end
      end
      ST_FREE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Channel data. Split mode hands channel 0 the most significant slice;
  // any low bits left over are simply not routed anywhere.
  for (genvar k = 0; k < NUM_CH; k++) begin : gen_ch
    if (COPY != 0) begin : gen_copy
      assign o_data_n[k*OW +: OW] = data_q;
    end else begin : gen_split
      assign o_data_n[k*OW +: OW] = data_q[DATA_WIDTHI-1-k*SLICE_WIDTH -: SLICE_WIDTH];
    end
  end

  logic unusedDataBits;
  assign unusedDataBits = ^data_q;

  assign o_driveNext_n = (state_q == ST_ISSUE) ? pending_q : '0;
  assign o_free        = (state_q == ST_FREE);
  assign o_busy        = (state_q != ST_IDLE);
  assign o_err         = err_q;
  assign o_token_cnt   = cnt_q;

endmodule

// File: tb/tb_c_splitter_n.sv
// ---------------------------------------------------------------------------
// tb_c_splitter_n
// Directed bench for c_splitter_n. Three instances share one clock:
//   dutA : defaults (split, FREE_DELAY=4)
//   dutB : COPY=1
//   dutC : FREE_DELAY=0, CNT_WIDTH=2
// Cycle k is the period just after clock edge k-1; the accepting edge of a
// token is edge 0. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_c_splitter_n;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  // dutA signals
  logic        aDrive;
  logic [31:0] aData;
  logic [3:0]  aMask;
  logic [3:0]  aFreeN;
  logic        aFree;
  logic [3:0]  aDrvN;
  logic [31:0] aDataN;
  logic        aBusy;
  logic        aErr;
  logic [15:0] aCnt;

  // dutB signals
  logic         bDrive;
  logic [31:0]  bData;
  logic [3:0]   bMask;
  logic [3:0]   bFreeN;
  logic         bFree;
  logic [3:0]   bDrvN;
  logic [127:0] bDataN;
  logic         bBusy;
  logic         bErr;
  logic [15:0]  bCnt;

  // dutC signals
  logic        cDrive;
  logic [31:0] cData;
  logic [3:0]  cMask;
  logic [3:0]  cFreeN;
  logic        cFree;
  logic [3:0]  cDrvN;
  logic [31:0] cDataN;
  logic        cBusy;
  logic        cErr;
  logic [1:0]  cCnt;

  c_splitter_n dutA (
    .clk(clk), .rstn(rstn), .i_drive(aDrive), .i_data(aData), .i_mask(aMask),
    .i_freeNext_n(aFreeN), .o_free(aFree), .o_driveNext_n(aDrvN), .o_data_n(aDataN),
    .o_busy(aBusy), .o_err(aErr), .o_token_cnt(aCnt)
  );

  c_splitter_n #(.COPY(1)) dutB (
    .clk(clk), .rstn(rstn), .i_drive(bDrive), .i_data(bData), .i_mask(bMask),
    .i_freeNext_n(bFreeN), .o_free(bFree), .o_driveNext_n(bDrvN), .o_data_n(bDataN),
    .o_busy(bBusy), .o_err(bErr), .o_token_cnt(bCnt)
  );

  c_splitter_n #(.FREE_DELAY(0), .CNT_WIDTH(2)) dutC (
    .clk(clk), .rstn(rstn), .i_drive(cDrive), .i_data(cData), .i_mask(cMask),
    .i_freeNext_n(cFreeN), .o_free(cFree), .o_driveNext_n(cDrvN), .o_data_n(cDataN),
    .o_busy(cBusy), .o_err(cErr), .o_token_cnt(cCnt)
  );

  int checks = 0;
  int errors = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Puts every input of every instance into its quiet value.
  task automatic applyStimulus();
    aDrive = 1'b0; aData = '0; aMask = '0; aFreeN = '0;
    bDrive = 1'b0; bData = '0; bMask = '0; bFreeN = '0;
    cDrive = 1'b0; cData = '0; cMask = '0; cFreeN = '0;
  endtask

  logic [1:0] cntExp [5];

  initial begin
    cntExp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    applyStimulus();
    rstn = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state of the default instance.
    checkOutput("rst_data", aDataN, 32'h0);
    checkOutput("rst_cnt",  aCnt,   16'h0);
    checkOutput("rst_err",  aErr,   1'b0);
    checkOutput("rst_busy", aBusy,  1'b0);
    checkOutput("rst_free", aFree,  1'b0);
    checkOutput("rst_drv",  aDrvN,  4'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Full split token; frees on ch0..3 at cycles 3,5,5,8.
    aDrive = 1'b1; aData = 32'hA1B2C3D4; aMask = 4'hF;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clk);
      aDrive = 1'b0;
      checkOutput("s1_drv",  aDrvN, (cyc == 1) ? 4'hF : 4'h0);
      checkOutput("s1_free", aFree, (cyc == 13) ? 1'b1 : 1'b0);
      checkOutput("s1_busy", aBusy, (cyc <= 13) ? 1'b1 : 1'b0);
      if (cyc == 1) begin
        checkOutput("s1_data", aDataN, 32'hD4C3B2A1);
        checkOutput("s1_cnt",  aCnt,   16'd1);
      end
      aFreeN = {cyc == 8, cyc == 5, cyc == 5, cyc == 3};
    end
    checkOutput("s1_err",  aErr,   1'b0);
    checkOutput("s1_hold", aDataN, 32'hD4C3B2A1);

    // Second drive during WAIT_FREE and a spurious free on masked ch3.
    @(negedge clk);
    aDrive = 1'b1; aData = 32'h01020304; aMask = 4'b0011;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      checkOutput("s4_err",  aErr,  (cyc >= 3) ? 1'b1 : 1'b0);
      checkOutput("s4_free", aFree, (cyc == 9) ? 1'b1 : 1'b0);
      checkOutput("s4_cnt",  aCnt,  16'd2);
      if (cyc == 1) begin
        checkOutput("s4_drv",  aDrvN,  4'b0011);
        checkOutput("s4_data", aDataN, 32'h04030201);
      end
      aDrive = (cyc == 2);
      aFreeN = (cyc == 4) ? 4'b0011 : ((cyc == 5) ? 4'b1000 : 4'b0000);
    end

    // Reset while the timer is running: no free for the aborted token.
    aDrive = 1'b1; aData = 32'hFFFFFFFF; aMask = 4'h0;
    @(negedge clk);
    aDrive = 1'b0;
    checkOutput("s5_busy", aBusy, 1'b1);
    checkOutput("s5_drv",  aDrvN, 4'h0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checkOutput("s5_rdata", aDataN, 32'h0);
    checkOutput("s5_rcnt",  aCnt,   16'h0);
    checkOutput("s5_rerr",  aErr,   1'b0);
    checkOutput("s5_rbusy", aBusy,  1'b0);
    @(negedge clk);
    rstn = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      checkOutput("s5_nofree", aFree, 1'b0);
    end
    aDrive = 1'b1; aData = 32'h0; aMask = 4'h0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      aDrive = 1'b0;
      checkOutput("s5_free", aFree, (cyc == 5) ? 1'b1 : 1'b0);
      checkOutput("s5_cnt",  aCnt,  16'd1);
    end

    // Copy mode, mask 0101; frees on ch0 at cycle 2 and ch2 at cycle 3.
    bDrive = 1'b1; bData = 32'h12345678; bMask = 4'b0101;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      bDrive = 1'b0;
      checkOutput("s2_drv",  bDrvN, (cyc == 1) ? 4'b0101 : 4'b0000);
      checkOutput("s2_free", bFree, (cyc == 8) ? 1'b1 : 1'b0);
      if (cyc == 1) begin
        checkOutput("s2_data", bDataN, {4{32'h12345678}});
      end
      bFreeN = (cyc == 2) ? 4'b0001 : ((cyc == 3) ? 4'b0100 : 4'b0000);
    end
    checkOutput("s2_err",  bErr,  1'b0);
    checkOutput("s2_cnt",  bCnt,  16'd1);
    checkOutput("s2_busy", bBusy, 1'b0);
    bFreeN = 4'b0010;
    @(negedge clk);
    bFreeN = 4'b0000;
    checkOutput("s2_spur", bErr, 1'b1);

    // Mask-zero tokens with no delay; 2-bit counter wraps.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cDrive = 1'b1;
      @(negedge clk);
      cDrive = 1'b0;
      checkOutput("s3_cnt",  cCnt,  cntExp[i]);
      checkOutput("s3_free", cFree, 1'b1);
      checkOutput("s3_drv",  cDrvN, 4'h0);
      checkOutput("s3_err",  cErr,  1'b0);
      @(negedge clk);
      checkOutput("s3_idle", cFree, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
